proc_seq_ctrl: RTL and testbench

PROC_SEQ_CTRL -- requirements
Module: proc_seq_ctrl

---
 rtl/proc_pkg.sv | 18 +
 rtl/rr_arb2.sv | 35 +++
 rtl/proc_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_proc_seq_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared FSM state encoding and engine status constants
package proc_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [1:0] ENG_IDLE = 2'b00;

    function automatic logic eng_is_idle(input logic [1:0] st);
        return st == ENG_IDLE;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with one-hot grant
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    // Index of the requester granted most recently; reset value lets req[0] win a tie.
    logic last_q, last_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        last_d = last_q;
        if (adv_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/proc_seq_ctrl.sv
// rtl/proc_seq_ctrl.sv - arbitrated run sequencer driving engine start/stop and per-run done pulses
module proc_seq_ctrl
    import proc_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       req_mode,
    input  logic [LEN_W-1:0] run_len,
    input  logic [1:0]       eng_state,
    output logic [1:0]       gnt,
    output logic             eng_start,
    output logic             eng_stop,
    output logic             eng_mode,
    output logic [1:0]       done,
    output logic             busy
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic             mode_q, mode_d;
    logic [1:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [1:0] arb_gnt;
    logic       arb_adv;
    logic       owner_req;
    logic       run_end;

    assign arb_adv   = (state_q == ST_IDLE) && (req != 2'b00) && eng_is_idle(eng_state);
    assign owner_req = req[gnt_q[1]];
    assign run_end   = (cnt_q == len_q - LEN_ONE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (reset),
        .req_i (req),
        .adv_i (arb_adv),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        stop_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_adv) begin
                    state_d = ST_START;
                    gnt_d   = arb_gnt;
                    mode_d  = req_mode[arb_gnt[1]];
                    len_d   = (run_len == '0) ? LEN_ONE : run_len;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                if (run_end) begin
                    if (mode_q && owner_req) begin
                        cnt_d = '0;
                    end else begin
                        state_d = ST_STOP;
                        stop_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + LEN_ONE;
                end
            end
            ST_STOP: begin
                state_d = ST_DRAIN;
                cnt_d   = '0;
            end
            ST_DRAIN: begin
                if (eng_is_idle(eng_state)) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    mode_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                mode_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Done is registered, so it is raised on the edge that enters the last count of a run.
        done_d = ((state_d == ST_RUN) && (cnt_d == len_d - LEN_ONE)) ? gnt_q : 2'b00;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            mode_q  <= 1'b0;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= LEN_ONE;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign gnt       = gnt_q;
    assign eng_start = start_q;
    assign eng_stop  = stop_q;
    assign eng_mode  = mode_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// tb/tb_proc_seq_ctrl.sv - self-checking bench for proc_seq_ctrl against a transaction timeline model
module tb_proc_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  req_mode;
    logic [15:0] run_len;
    logic [1:0]  eng_state;
    logic [1:0]  gnt;
    logic        eng_start;
    logic        eng_stop;
    logic        eng_mode;
    logic [1:0]  done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int last_w   = 1;

    always #5 clk = ~clk;

    proc_seq_ctrl #(.LEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_mode  (req_mode),
        .run_len   (run_len),
        .eng_state (eng_state),
        .gnt       (gnt),
        .eng_start (eng_start),
        .eng_stop  (eng_stop),
        .eng_mode  (eng_mode),
        .done      (done),
        .busy      (busy)
    );

    function automatic logic [7:0] outs();
        return {gnt, eng_start, eng_stop, eng_mode, done, busy};
    endfunction

    // One whole transaction from an IDLE cycle (cycle 0) to the next IDLE cycle.
    // Expected outputs per cycle follow from the timing rules: start at cycle 1, done every
    // L cycles after start, stop one cycle after the last done, grant held through drain.
    task automatic do_txn(input string tag, input logic [1:0] rq, input logic [1:0] md,
                          input int len, input int runs, input int dly,
                          input bit other_hi, input bit noise);
        int         w;
        int         l_eff;
        int         r_eff;
        int         stop_c;
        int         idle_c;
        logic [1:0] w_oh;
        logic [7:0] exp_v;
        logic [7:0] act_v;
        if (rq == 2'b11) w = (last_w == 1) ? 0 : 1;
        else             w = rq[1] ? 1 : 0;
        last_w = w;
        w_oh   = (w == 1) ? 2'b10 : 2'b01;
        l_eff  = (len == 0) ? 1 : len;
        r_eff  = md[w] ? runs : 1;
        stop_c = 2 + r_eff * l_eff;
        idle_c = stop_c + dly + 2;
        req       = rq;
        req_mode  = md;
        run_len   = 16'(len);
        eng_state = 2'b00;
        for (int k = 1; k <= idle_c; k++) begin
            @(negedge clk);
            exp_v[7:6] = (k < idle_c) ? w_oh : 2'b00;
            exp_v[5]   = (k == 1);
            exp_v[4]   = (k == stop_c);
            exp_v[3]   = (k < idle_c) ? md[w] : 1'b0;
            exp_v[2:1] = (k > 1 && k < stop_c && ((k - 1) % l_eff) == 0) ? w_oh : 2'b00;
            exp_v[0]   = (k < idle_c);
            act_v = outs();
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: {gnt,start,stop,mode,done,busy} got %b expected %b",
                         tag, k, act_v, exp_v);
            end
            req[w]     = (k < (r_eff - 1) * l_eff + 2);
            req[1 - w] = noise ? 1'($urandom_range(0, 1)) : other_hi;
            if (noise) begin
                req_mode = 2'($urandom_range(0, 3));
                run_len  = 16'($urandom);
            end
            if (k < stop_c)                eng_state = noise ? 2'($urandom_range(0, 3)) : 2'b01;
            else if (k < stop_c + dly + 1) eng_state = 2'($urandom_range(1, 3));
            else                           eng_state = 2'b00;
            if (k == idle_c) req = 2'b00;
        end
    endtask

    task automatic test_reset();
        req       = 2'b11;
        req_mode  = 2'b11;
        run_len   = 16'd3;
        eng_state = 2'b00;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        last_w    = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs() !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold: outputs got %b expected %b", outs(), 8'h00);
            end
        end
        req   = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs() !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: outputs got %b expected %b", outs(), 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        do_txn("b2b_first", 2'b11, 2'b00, 2, 1, 0, 1'b1, 1'b0);
        do_txn("b2b_second", 2'b11, 2'b00, 2, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_mode0_basic();
        do_txn("mode0_len4", 2'b01, 2'b00, 4, 1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_continuous();
        do_txn("cont_len2x3", 2'b10, 2'b10, 2, 3, 1, 1'b0, 1'b0);
        do_txn("cont_len1x3", 2'b01, 2'b01, 1, 3, 0, 1'b1, 1'b0);
    endtask

    task automatic test_zero_len();
        do_txn("zero_len_m0", 2'b10, 2'b00, 0, 1, 0, 1'b0, 1'b0);
        do_txn("zero_len_m1", 2'b01, 2'b01, 0, 2, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        req       = 2'b01;
        req_mode  = 2'b00;
        run_len   = 16'd10;
        eng_state = 2'b00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_busy: busy got %b expected %b", busy, 1'b1);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (outs() !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_async_clear: outputs got %b expected %b", outs(), 8'h00);
        end
        last_w    = 1;
        req       = 2'b11;
        eng_state = 2'b01;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs() !== 8'h00) begin
                n_fail++;
                $display("FAIL midrun_wait_engine cycle %0d: outputs got %b expected %b", k, outs(), 8'h00);
            end
        end
        do_txn("post_reset", 2'b11, 2'b00, 2, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_drain_hold();
        do_txn("drain_hold", 2'b01, 2'b00, 3, 1, 5, 1'b1, 1'b0);
        do_txn("drain_pending", 2'b10, 2'b00, 2, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            do_txn("random", 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 5)), int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 4)), 1'b0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mode0_basic();
        test_continuous();
        test_zero_len();
        test_reset_mid_run();
        test_drain_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
